// File: rtl/wbu_pkg.sv
// Shared write-back configuration.
//   ARGS_WIDTH      : width of the register write-source select
//   REG_WR_SRC_*    : result-source codes (ALU, LSU load data, PC+4)
//   INST_LEN_BYTES  : instruction length increment used for the link value
// The macro forms are kept for files that still use the shared cfg macros.

`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`endif
`ifndef REG_WR_SRC_ALU
`define REG_WR_SRC_ALU 0
`endif
`ifndef REG_WR_SRC_LSU
`define REG_WR_SRC_LSU 1
`endif
`ifndef REG_WR_SRC_PC
`define REG_WR_SRC_PC 2
`endif
`ifndef INST_LEN_BYTES
`define INST_LEN_BYTES 4
`endif

package wbu_pkg;

  localparam int ARGS_WIDTH = `ARGS_WIDTH;

  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_ALU = ARGS_WIDTH'(`REG_WR_SRC_ALU);
  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_LSU = ARGS_WIDTH'(`REG_WR_SRC_LSU);
  localparam logic [ARGS_WIDTH-1:0] REG_WR_SRC_PC  = ARGS_WIDTH'(`REG_WR_SRC_PC);

  localparam int INST_LEN_BYTES = `INST_LEN_BYTES;

  localparam int INSTRET_WIDTH = 64;

endpackage

// File: rtl/wbu_fifo.sv
// Generic DEPTH x W synchronous FIFO with count-based full/empty.
//   clk, rst : clock and asynchronous active-high reset
//   push     : write wdata when not full
//   pop      : drop the head entry when not empty
//   rdata    : head entry (valid while !empty)
//   count    : number of stored entries
//   full     : count == DEPTH
//   empty    : count == 0
// DEPTH must be a power of two so the pointers wrap naturally.

module wbu_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; stale contents are never visible while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wbu.sv
// Write-back unit: selects the register result, buffers it in order and
// retires one instruction per commit handshake.
//   i_sys_clk / i_sys_rst        : clock, asynchronous active-high reset
//   i_lsu_valid / o_wbu_ready    : upstream enqueue handshake
//   i_idu_ctr_reg_wr_en/_src     : GPR write enable and result-source select
//   i_idu_gpr_rd_addr            : destination register
//   i_exu_res, i_lsu_gpr_wr_data : ALU result, extended load data
//   i_ifu_pc                     : PC of the instruction
//   o_wbu_valid / i_sys_ready    : commit handshake
//   o_wbu_gpr_wr_en/_addr/_data  : GPR write port (strobe per commit)
//   o_wbu_pc                     : PC of the committing instruction
//   o_wbu_instret                : retired-instruction counter

module wbu
  import wbu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 2
) (
  input  logic                      i_sys_clk,
  input  logic                      i_sys_rst,
  input  logic                      i_lsu_valid,
  output logic                      o_wbu_ready,
  input  logic                      i_idu_ctr_reg_wr_en,
  input  logic [ARGS_WIDTH-1:0]     i_idu_ctr_reg_wr_src,
  input  logic [REG_ADDR_WIDTH-1:0] i_idu_gpr_rd_addr,
  input  logic [DATA_WIDTH-1:0]     i_exu_res,
  input  logic [DATA_WIDTH-1:0]     i_lsu_gpr_wr_data,
  input  logic [DATA_WIDTH-1:0]     i_ifu_pc,
  output logic                      o_wbu_valid,
  input  logic                      i_sys_ready,
  output logic                      o_wbu_gpr_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] o_wbu_gpr_wr_addr,
  output logic [DATA_WIDTH-1:0]     o_wbu_gpr_wr_data,
  output logic [DATA_WIDTH-1:0]     o_wbu_pc,
  output logic [INSTRET_WIDTH-1:0]  o_wbu_instret
);

  typedef struct packed {
    logic                      wr_en;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [DATA_WIDTH-1:0]     pc;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  wb_entry_t               enq_entry;
  wb_entry_t               head;
  logic [ENTRY_W-1:0]      head_raw;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    enq_fire;
  logic                    commit_fire;

  assign o_wbu_ready = !fifo_full;
  assign o_wbu_valid = !fifo_empty;
  assign enq_fire    = i_lsu_valid && o_wbu_ready;
  assign commit_fire = o_wbu_valid && i_sys_ready;

  always_comb begin
    sel_data = '0;
    case (i_idu_ctr_reg_wr_src)
      REG_WR_SRC_ALU: sel_data = i_exu_res;
      REG_WR_SRC_LSU: sel_data = i_lsu_gpr_wr_data;
      REG_WR_SRC_PC:  sel_data = i_ifu_pc + DATA_WIDTH'(INST_LEN_BYTES);
      default:        sel_data = '0;
    endcase
  end

  // x0 is hardwired to zero, so its write enable is dropped at enqueue.
  always_comb begin
    enq_entry         = '0;
    enq_entry.wr_en   = i_idu_ctr_reg_wr_en && (i_idu_gpr_rd_addr != '0);
    enq_entry.rd_addr = i_idu_gpr_rd_addr;
    enq_entry.wr_data = sel_data;
    enq_entry.pc      = i_ifu_pc;
  end

  wbu_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_sys_clk),
    .rst   (i_sys_rst),
    .push  (enq_fire),
    .pop   (commit_fire),
    .wdata (enq_entry),
    .rdata (head_raw),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head = wb_entry_t'(head_raw);

  // Head fields are masked while empty so unreset storage never leaks out.
  always_comb begin
    o_wbu_gpr_wr_en   = 1'b0;
    o_wbu_gpr_wr_addr = '0;
    o_wbu_gpr_wr_data = '0;
    o_wbu_pc          = '0;
    if (!fifo_empty) begin
      o_wbu_gpr_wr_en   = commit_fire && head.wr_en;
      o_wbu_gpr_wr_addr = head.rd_addr;
      o_wbu_gpr_wr_data = head.wr_data;
      o_wbu_pc          = head.pc;
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      o_wbu_instret <= '0;
    end else if (commit_fire) begin
      o_wbu_instret <= o_wbu_instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_wbu.sv
module tb_wbu;
  import wbu_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  lsu_valid;
  logic                  wbu_ready;
  logic                  reg_wr_en;
  logic [ARGS_WIDTH-1:0] reg_wr_src;
  logic [4:0]            rd_addr;
  logic [31:0]           exu_res;
  logic [31:0]           lsu_data;
  logic [31:0]           ifu_pc;
  logic                  wbu_valid;
  logic                  sys_ready;
  logic                  gpr_wr_en;
  logic [4:0]            gpr_wr_addr;
  logic [31:0]           gpr_wr_data;
  logic [31:0]           wbu_pc;
  logic [63:0]           instret;

  int errors = 0;
  int checks = 0;

  wbu #(
    .DATA_WIDTH     (32),
    .REG_ADDR_WIDTH (5),
    .DEPTH          (2)
  ) dut (
    .i_sys_clk            (clk),
    .i_sys_rst            (rst),
    .i_lsu_valid          (lsu_valid),
    .o_wbu_ready          (wbu_ready),
    .i_idu_ctr_reg_wr_en  (reg_wr_en),
    .i_idu_ctr_reg_wr_src (reg_wr_src),
    .i_idu_gpr_rd_addr    (rd_addr),
    .i_exu_res            (exu_res),
    .i_lsu_gpr_wr_data    (lsu_data),
    .i_ifu_pc             (ifu_pc),
    .o_wbu_valid          (wbu_valid),
    .i_sys_ready          (sys_ready),
    .o_wbu_gpr_wr_en      (gpr_wr_en),
    .o_wbu_gpr_wr_addr    (gpr_wr_addr),
    .o_wbu_gpr_wr_data    (gpr_wr_data),
    .o_wbu_pc             (wbu_pc),
    .o_wbu_instret        (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wen, input logic [ARGS_WIDTH-1:0] src,
                       input logic [4:0] rd, input logic [31:0] exu,
                       input logic [31:0] lsu, input logic [31:0] pc);
    lsu_valid  = v;
    reg_wr_en  = wen;
    reg_wr_src = src;
    rd_addr    = rd;
    exu_res    = exu;
    lsu_data   = lsu;
    ifu_pc     = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    sys_ready = 1'b0;
    drive(1'b0, 1'b0, REG_WR_SRC_ALU, 5'd0, 32'h0, 32'h0, 32'h0);
    #12;
    check("rst_ready",   wbu_ready, 1);
    check("rst_valid",   wbu_valid, 0);
    check("rst_instret", instret,   0);
    check("rst_wr_en",   gpr_wr_en, 0);
    check("rst_pc",      wbu_pc,    0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single ALU entry
    drive(1'b1, 1'b1, REG_WR_SRC_ALU, 5'd5, 32'h1234, 32'h0, 32'h100);
    sys_ready = 1'b1;
    #1;
    check("alu_pre_valid", wbu_valid, 0);
    check("alu_pre_wr_en", gpr_wr_en, 0);
    step();
    lsu_valid = 1'b0;
    #1;
    check("alu_valid", wbu_valid,   1);
    check("alu_wr_en", gpr_wr_en,   1);
    check("alu_addr",  gpr_wr_addr, 5);
    check("alu_data",  gpr_wr_data, 32'h1234);
    check("alu_pc",    wbu_pc,      32'h100);
    step();
    check("alu_instret", instret,     1);
    check("alu_empty",   wbu_valid,   0);
    check("alu_no_str",  gpr_wr_en,   0);
    check("alu_data0",   gpr_wr_data, 0);

    // LSU then PC+4 wrap, buffered then retired in order
    sys_ready = 1'b0;
    drive(1'b1, 1'b1, REG_WR_SRC_LSU, 5'd1, 32'h0, 32'hffff_ff80, 32'h200);
    step();
    drive(1'b1, 1'b1, REG_WR_SRC_PC, 5'd1, 32'h0, 32'h0, 32'hffff_fffc);
    step();
    lsu_valid = 1'b0;
    sys_ready = 1'b1;
    #1;
    check("lp_full",   wbu_ready,   0);
    check("lp1_wr_en", gpr_wr_en,   1);
    check("lp1_data",  gpr_wr_data, 32'hffff_ff80);
    check("lp1_pc",    wbu_pc,      32'h200);
    step();
    check("lp2_wr_en", gpr_wr_en,   1);
    check("lp2_addr",  gpr_wr_addr, 1);
    check("lp2_data",  gpr_wr_data, 32'h0);
    check("lp2_pc",    wbu_pc,      32'hffff_fffc);
    step();
    check("lp_instret", instret,   3);
    check("lp_empty",   wbu_valid, 0);

    // write to x0 commits but never strobes
    drive(1'b1, 1'b1, REG_WR_SRC_ALU, 5'd0, 32'hdead, 32'h0, 32'h300);
    step();
    lsu_valid = 1'b0;
    #1;
    check("x0_valid", wbu_valid,   1);
    check("x0_wr_en", gpr_wr_en,   0);
    check("x0_data",  gpr_wr_data, 32'hdead);
    step();
    check("x0_instret", instret, 4);

    // backpressure with three offered, then sustained flow
    sys_ready = 1'b0;
    drive(1'b1, 1'b1, REG_WR_SRC_ALU, 5'd2, 32'h11, 32'h0, 32'h400);
    step();
    drive(1'b1, 1'b1, REG_WR_SRC_ALU, 5'd3, 32'h22, 32'h0, 32'h404);
    step();
    drive(1'b1, 1'b1, REG_WR_SRC_ALU, 5'd4, 32'h33, 32'h0, 32'h408);
    #1;
    check("bp_ready0", wbu_ready, 0);
    check("bp_head_a", gpr_wr_data, 32'h11);
    check("bp_no_str", gpr_wr_en, 0);
    step();
    check("bp_held",   wbu_ready, 0);
    check("bp_head_a2", gpr_wr_data, 32'h11);
    sys_ready = 1'b1;
    #1;
    check("bp_a_str",  gpr_wr_en,   1);
    check("bp_a_addr", gpr_wr_addr, 2);
    step();
    check("bp_ready1",  wbu_ready,   1);
    check("bp_b_data",  gpr_wr_data, 32'h22);
    check("bp_b_str",   gpr_wr_en,   1);
    step();
    drive(1'b1, 1'b1, REG_WR_SRC_ALU, 5'd6, 32'h44, 32'h0, 32'h40c);
    #1;
    check("ss_c_data",  gpr_wr_data, 32'h33);
    check("ss_c_addr",  gpr_wr_addr, 4);
    check("ss_ready",   wbu_ready,   1);
    check("ss_valid",   wbu_valid,   1);
    check("ss_instret", instret,     6);
    step();
    lsu_valid = 1'b0;
    #1;
    check("ss_d_data", gpr_wr_data, 32'h44);
    check("ss_d_pc",   wbu_pc,      32'h40c);
    step();
    check("bp_instret", instret,   8);
    check("bp_empty",   wbu_valid, 0);

    // asynchronous reset with two entries buffered
    sys_ready = 1'b0;
    drive(1'b1, 1'b1, REG_WR_SRC_ALU, 5'd7, 32'h55, 32'h0, 32'h500);
    step();
    drive(1'b1, 1'b1, REG_WR_SRC_ALU, 5'd8, 32'h66, 32'h0, 32'h504);
    step();
    lsu_valid = 1'b0;
    #1;
    check("ar_full",  wbu_ready,   0);
    check("ar_head",  gpr_wr_data, 32'h55);
    #1;
    rst       = 1'b1;
    sys_ready = 1'b1;
    #1;
    check("ar_valid",   wbu_valid,   0);
    check("ar_ready",   wbu_ready,   1);
    check("ar_instret", instret,     0);
    check("ar_wr_en",   gpr_wr_en,   0);
    check("ar_addr",    gpr_wr_addr, 0);
    check("ar_data",    gpr_wr_data, 0);
    check("ar_pc",      wbu_pc,      0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("ar_post_wr_en",   gpr_wr_en, 0);
    check("ar_post_valid",   wbu_valid, 0);
    check("ar_post_instret", instret,   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wbu.md
Name: wbu

Overview:
- Write-back stage of the core. It sits directly downstream of lsu and consumes the GPR write data that lsu produces.
- Selects the final register result from the EXU result, the LSU load data or PC+4, and buffers it in a small in-order FIFO.
- Retires one instruction per commit handshake: drives the GPR write port and increments a 64-bit retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, width of GPR data, EXU result, LSU data and PC.
- REG_ADDR_WIDTH, 5, GPR index width.
- DEPTH, 2, number of buffer entries; must be a power of two, at least 2.

Ports:
- i_sys_clk  in  1  core clock, rising edge.
- i_sys_rst  in  1  asynchronous, active-high reset.
- i_lsu_valid  in  1  upstream entry valid.
- o_wbu_ready  out  1  buffer can accept an entry.
- i_idu_ctr_reg_wr_en  in  1  instruction writes a GPR.
- i_idu_ctr_reg_wr_src  in  `ARGS_WIDTH  result-source select.
- i_idu_gpr_rd_addr  in  REG_ADDR_WIDTH  destination register.
- i_exu_res  in  DATA_WIDTH  ALU result.
- i_lsu_gpr_wr_data  in  DATA_WIDTH  extended load data from lsu.
- i_ifu_pc  in  DATA_WIDTH  PC of the instruction.
- o_wbu_valid  out  1  head entry ready to commit.
- i_sys_ready  in  1  downstream accepts the commit.
- o_wbu_gpr_wr_en  out  1  GPR write strobe.
- o_wbu_gpr_wr_addr  out  REG_ADDR_WIDTH  GPR write index.
- o_wbu_gpr_wr_data  out  DATA_WIDTH  GPR write value.
- o_wbu_pc  out  DATA_WIDTH  PC of the committing instruction.
- o_wbu_instret  out  64  count of retired instructions.

Behaviour:
- Enqueue fires when i_lsu_valid && o_wbu_ready. Commit fires when o_wbu_valid && i_sys_ready.
- o_wbu_ready = (count != DEPTH). This is combinational from the registered count only; there is no enqueue-when-full bypass.
- o_wbu_valid = (count != 0). It is registered state; it never combinationally depends on i_lsu_valid.
- Latency: an entry enqueued at edge N is visible on the head outputs after edge N; it commits at edge N+1 at the earliest.
- Result select, done at enqueue:
  - `REG_WR_SRC_ALU -> i_exu_res.
  - `REG_WR_SRC_LSU -> i_lsu_gpr_wr_data.
  - `REG_WR_SRC_PC -> i_ifu_pc + 4, truncated to DATA_WIDTH so it wraps modulo 2^DATA_WIDTH.
  - Any other code -> 0.
- Stored entry = {wr_en, rd_addr, wr_data, pc}. wr_en is stored as i_idu_ctr_reg_wr_en && (rd_addr != 0), so x0 is never written.
- Head outputs:
  - o_wbu_gpr_wr_en = commit fire && head.wr_en. It is a one-cycle strobe per commit.
  - o_wbu_gpr_wr_addr, o_wbu_gpr_wr_data and o_wbu_pc show the head entry whenever count != 0, and 0 when empty.
- Pointers: rd_ptr and wr_ptr are log2(DEPTH) bits wide and wrap naturally; count is log2(DEPTH)+1 bits.
  - Enqueue and commit in the same cycle: both pointers advance and count is unchanged. This is legal only when 0 < count < DEPTH.
  - Empty: no commit is possible and no strobe is issued.
  - Full: upstream stalls; commit still proceeds.
- Entries retire strictly in enqueue order.
- o_wbu_instret increments by 1 on each commit fire and wraps at 2^64 to 0.
- Reset, including mid-operation, asynchronously forces:
  - count = 0, pointers = 0, o_wbu_instret = 0;
  - o_wbu_valid = 0, o_wbu_ready = 1, all GPR write outputs = 0, o_wbu_pc = 0.
  - Buffered entries are discarded.
- Storage contents need no reset.

Decomposition:
- Add to the shared cfg.sv: `REG_WR_SRC_ALU = 0, `REG_WR_SRC_LSU = 1, `REG_WR_SRC_PC = 2, encoded in `ARGS_WIDTH bits.
- Add a constant for the instruction length increment of 4.
- One natural sub-module: wbu_fifo. It is a generic DEPTH×W synchronous FIFO with count-based full/empty and asynchronous active-high reset.
- The top level keeps result-select, the x0 masking and the instret counter.

Test Plan:
- Reset then idle -> o_wbu_ready=1, o_wbu_valid=0, o_wbu_instret=0, o_wbu_gpr_wr_en=0.
- One entry with src=ALU, rd=5, exu=32'h1234, wr_en=1, i_sys_ready=1 -> next cycle valid=1; commit strobe with addr=5, data=32'h1234; instret=1.
- src=LSU with data 32'hffff_ff80, then src=PC with pc=32'hffff_fffc, both rd=1 -> two in-order writes: data 32'hffff_ff80, then 32'h0 (PC+4 wrap).
- rd=0 with wr_en=1 -> commit happens and instret increments, but o_wbu_gpr_wr_en stays 0.
- i_sys_ready=0 while 3 entries are offered -> two accepted; o_wbu_ready=0 with the third held. Raise i_sys_ready -> the three retire in order; sustained enqueue+commit keeps count=1 with one commit per cycle.
- Reset asserted mid-cycle with 2 entries buffered -> outputs clear immediately (asynchronously), instret=0, no strobe after reset release.
